// File: rtl/mem_rd_pkg.sv
// Shared types and defaults for the dual-client memory read-return path.
// Latency: n/a (types only). Backpressure: n/a.
// Contents: width/latency defaults, client identifier enum, in-flight tag struct.
package mem_rd_pkg;

  localparam int DEF_ADDR_W     = 8;
  localparam int DEF_DATA_W     = 8;
  localparam int DEF_RD_LATENCY = 2;

  typedef enum logic {
    CLIENT1 = 1'b0,
    CLIENT2 = 1'b1
  } client_e;

  typedef struct packed {
    logic    valid;
    client_e client;
  } rd_tag_t;

endpackage

// File: rtl/rd_tag_pipe.sv
// Shift pipeline carrying one {valid, client} tag per issued read to the return point.
// Latency: DEPTH cycles from tag_in to tag_out. Backpressure: none, advances every clock.
// Ports: clk, rst_n (async, active-low), flush (sync clear of all stages),
//        tag_in (tag of this cycle's accepted read), tag_out (oldest stage), busy (any stage valid).
module rd_tag_pipe
  import mem_rd_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    flush,
  input  rd_tag_t tag_in,
  output rd_tag_t tag_out,
  output logic    busy
);

  rd_tag_t stage [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign tag_out = stage[DEPTH-1];

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < DEPTH; i++) busy = busy | stage[i].valid;
  end

endmodule

// File: rtl/mem_read_return.sv
// Arbitrates two read clients onto one memory port and steers returned data to the issuer.
// Latency: RD_LATENCY+1 cycles from acceptance to rdN_valid; one read per cycle throughput.
// Backpressure: reqN_ready is the combinational grant; losing client holds valid/addr.
// Ports: clk, rst_n, first_done (priority phase), flush, req1/req2 valid/addr/ready,
//        mem_address/mem_wren/mem_q (memory port), rd1/rd2 valid/data (returns), busy.
module mem_read_return
  import mem_rd_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int RD_LATENCY = DEF_RD_LATENCY
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              first_done,
  input  logic              flush,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  output logic              req1_ready,
  input  logic              req2_valid,
  input  logic [ADDR_W-1:0] req2_addr,
  output logic              req2_ready,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q,
  output logic              rd1_valid,
  output logic [DATA_W-1:0] rd1_data,
  output logic              rd2_valid,
  output logic [DATA_W-1:0] rd2_data,
  output logic              busy
);

  logic    grant1, grant2, can_accept;
  rd_tag_t tag_in, tag_out;
  logic    ret1, ret2;

  // first_done=0 favours client 1, first_done=1 favours client 2.
  assign grant1     = req1_valid && (!first_done || !req2_valid);
  assign grant2     = req2_valid && ( first_done || !req1_valid);
  // Reset and flush both block acceptance; ready is gated directly by rst_n.
  assign can_accept = rst_n && !flush;
  assign req1_ready = grant1 && can_accept;
  assign req2_ready = grant2 && can_accept;

  assign mem_wren = 1'b0;

  always_comb begin
    tag_in        = '0;
    tag_in.valid  = req1_ready || req2_ready;
    tag_in.client = req2_ready ? CLIENT2 : CLIENT1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_address <= '0;
    end else if (req1_ready) begin
      mem_address <= req1_addr;
    end else if (req2_ready) begin
      mem_address <= req2_addr;
    end
  end

  rd_tag_pipe #(
    .DEPTH (RD_LATENCY + 1)
  ) u_tag_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .tag_in  (tag_in),
    .tag_out (tag_out),
    .busy    (busy)
  );

  // The oldest tag lines up with mem_q for its read; a flush on that same
  // edge discards it along with everything else in flight.
  assign ret1 = tag_out.valid && (tag_out.client == CLIENT1) && !flush;
  assign ret2 = tag_out.valid && (tag_out.client == CLIENT2) && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd1_valid <= 1'b0;
      rd2_valid <= 1'b0;
      rd1_data  <= '0;
      rd2_data  <= '0;
    end else begin
      rd1_valid <= ret1;
      rd2_valid <= ret2;
      if (ret1) rd1_data <= mem_q;
      if (ret2) rd2_data <= mem_q;
    end
  end

endmodule

// File: tb/tb_mem_read_return.sv
// Scoreboard bench for mem_read_return with a 2-cycle 256x8 memory model.
// Latency: n/a. Backpressure: bench holds a pending request until granted.
// Driver pushes expected returns on acceptance; monitor pops and compares on each rd strobe.
module tb_mem_read_return;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       first_done = 1'b0;
  logic       flush = 1'b0;
  logic       req1_valid = 1'b0, req2_valid = 1'b0;
  logic [7:0] req1_addr = '0, req2_addr = '0;
  logic       req1_ready, req2_ready;
  logic [7:0] mem_address;
  logic       mem_wren;
  logic [7:0] mem_q;
  logic       rd1_valid, rd2_valid;
  logic [7:0] rd1_data, rd2_data;
  logic       busy;

  always #5 clk = ~clk;

  mem_read_return dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .first_done  (first_done),
    .flush       (flush),
    .req1_valid  (req1_valid),
    .req1_addr   (req1_addr),
    .req1_ready  (req1_ready),
    .req2_valid  (req2_valid),
    .req2_addr   (req2_addr),
    .req2_ready  (req2_ready),
    .mem_address (mem_address),
    .mem_wren    (mem_wren),
    .mem_q       (mem_q),
    .rd1_valid   (rd1_valid),
    .rd1_data    (rd1_data),
    .rd2_valid   (rd2_valid),
    .rd2_data    (rd2_data),
    .busy        (busy)
  );

  // Memory model: address sampled one edge after it is presented, q one edge later.
  logic [7:0] mem [256];
  logic [7:0] m1 = '0;
  always @(posedge clk) begin
    m1    <= mem[mem_address];
    mem_q <= m1;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         client;
    logic [7:0] data;
    int         due;
  } exp_t;

  exp_t       sbq[$];
  int         checks = 0;
  int         failures = 0;
  logic [7:0] exp_addr = '0;
  logic [7:0] last1 = '0, last2 = '0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: runs at every falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      while (sbq.size() > 0 && sbq[0].due < cyc) begin
        chk("missing_return_due", cyc, sbq[0].due);
        void'(sbq.pop_front());
      end
      if (rd1_valid && rd2_valid) chk("both_rd_valid", 1, 0);
      if (rd1_valid || rd2_valid) begin
        if (sbq.size() == 0) begin
          chk("unexpected_return", 1, 0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("return_cycle", cyc, e.due);
          chk("return_client", rd2_valid ? 2 : 1, e.client);
          if (rd1_valid) begin
            chk("rd1_data", rd1_data, e.data);
            last1 = e.data;
          end else begin
            chk("rd2_data", rd2_data, e.data);
            last2 = e.data;
          end
        end
      end
      if (!rd1_valid) chk("rd1_data_hold", rd1_data, last1);
      if (!rd2_valid) chk("rd2_data_hold", rd2_data, last2);
      chk("busy", busy, sbq.size() != 0);
      chk("mem_address", mem_address, exp_addr);
      chk("mem_wren", mem_wren, 0);
    end
  end

  // One cycle of stimulus: drive after the falling edge, check readies
  // against the arbitration rule, and record what the coming edge accepts.
  task automatic cycle(input logic v1, input logic [7:0] x1,
                       input logic v2, input logic [7:0] x2,
                       input logic fd, input logic fl,
                       output logic g1, output logic g2);
    @(negedge clk);
    req1_valid = v1; req1_addr = x1;
    req2_valid = v2; req2_addr = x2;
    first_done = fd; flush = fl;
    #1;
    g1 = !fl && v1 && (!fd || !v2);
    g2 = !fl && v2 && (fd || !v1);
    chk("req1_ready", req1_ready, g1);
    chk("req2_ready", req2_ready, g2);
    if (fl) sbq.delete();
    if (g1) begin
      sbq.push_back('{1, mem[x1], cyc + 4});
      exp_addr = x1;
    end else if (g2) begin
      sbq.push_back('{2, mem[x2], cyc + 4});
      exp_addr = x2;
    end
  endtask

  task automatic idle(input int n);
    logic a, b;
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, 8'h00, first_done, 1'b0, a, b);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rd1_valid"}, rd1_valid, 0);
    chk({tag, "_rd2_valid"}, rd2_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_mem_address"}, mem_address, 0);
    chk({tag, "_rd1_data"}, rd1_data, 0);
    chk({tag, "_rd2_data"}, rd2_data, 0);
    chk({tag, "_req1_ready"}, req1_ready, 0);
    chk({tag, "_req2_ready"}, req2_ready, 0);
  endtask

  initial begin
    logic g1, g2, p1, p2, fd;
    logic [7:0] a1, a2;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);

    // Reset held from time zero with a request already presented.
    req1_valid = 1'b1; req2_valid = 1'b1;
    #1;
    check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    req1_valid = 1'b0; req2_valid = 1'b0;
    rst_n = 1'b1;

    // Single read, client 1.
    idle(1);
    cycle(1'b1, 8'h10, 1'b0, 8'h00, 1'b0, 1'b0, g1, g2);
    idle(5);

    // Contention, client 1 priority then client 2 priority.
    cycle(1'b1, 8'h20, 1'b1, 8'h30, 1'b0, 1'b0, g1, g2);
    cycle(1'b0, 8'h20, 1'b1, 8'h30, 1'b0, 1'b0, g1, g2);
    idle(5);
    cycle(1'b1, 8'h20, 1'b1, 8'h30, 1'b1, 1'b0, g1, g2);
    cycle(1'b1, 8'h20, 1'b0, 8'h30, 1'b1, 1'b0, g1, g2);
    idle(5);

    // Priority flips while reads are in flight.
    cycle(1'b0, 8'h00, 1'b1, 8'h55, 1'b1, 1'b0, g1, g2);
    cycle(1'b1, 8'h66, 1'b0, 8'h00, 1'b0, 1'b0, g1, g2);
    cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, g1, g2);
    idle(5);

    // Streaming: client 2 reads every address back to back.
    for (int i = 0; i < 256; i++) cycle(1'b0, 8'h00, 1'b1, 8'(i), 1'b0, 1'b0, g1, g2);
    idle(5);

    // Flush on the third of five reads, with a request present.
    cycle(1'b1, 8'h40, 1'b0, 8'h00, 1'b0, 1'b0, g1, g2);
    cycle(1'b1, 8'h41, 1'b0, 8'h00, 1'b0, 1'b0, g1, g2);
    cycle(1'b1, 8'h42, 1'b0, 8'h00, 1'b0, 1'b1, g1, g2);
    cycle(1'b1, 8'h43, 1'b0, 8'h00, 1'b0, 1'b0, g1, g2);
    cycle(1'b1, 8'h44, 1'b0, 8'h00, 1'b0, 1'b0, g1, g2);
    idle(5);

    // Reset asserted between edges with two reads in flight.
    cycle(1'b1, 8'h50, 1'b0, 8'h00, 1'b0, 1'b0, g1, g2);
    cycle(1'b0, 8'h00, 1'b1, 8'h51, 1'b0, 1'b0, g1, g2);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    sbq.delete();
    exp_addr = '0; last1 = '0; last2 = '0;
    req1_valid = 1'b0; req2_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b0, 8'h00, 1'b1, 8'h77, 1'b0, 1'b0, g1, g2);
    idle(6);

    // Randomized traffic over random memory contents.
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    p1 = 0; p2 = 0; a1 = 0; a2 = 0; fd = 0;
    for (int n = 0; n < 600; n++) begin
      if (!p1 && ($urandom % 3 != 0)) begin p1 = 1; a1 = 8'($urandom); end
      if (!p2 && ($urandom % 3 != 0)) begin p2 = 1; a2 = 8'($urandom); end
      if ($urandom % 8 == 0) fd = !fd;
      cycle(p1, a1, p2, a2, fd, ($urandom % 25 == 0), g1, g2);
      if (g1) p1 = 0;
      if (g2) p2 = 0;
    end
    idle(6);
    chk("drain_empty", sbq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_read_return.md
MEM_READ_RETURN -- requirements
Module: mem_read_return

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 8, address width; DATA_W, default 8, data width; RD_LATENCY, default 2, memory cycles from address to valid q.
REQ-002 The block SHALL use one clock and one reset: clk is the single clock; rst_n is asynchronous and active-low.
REQ-003 Ports SHALL be as follows (name, direction, width, meaning):
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- first_done  in  1  phase select: 0 gives client 1 priority, 1 gives client 2 priority
- flush  in  1  synchronous discard of all in-flight reads
- req1_valid, req2_valid  in  1  read request from client 1 / client 2
- req1_addr, req2_addr  in  ADDR_W  read address
- req1_ready, req2_ready  out  1  request accepted this cycle
- mem_address  out  ADDR_W  registered address to the 256x8 on-chip memory
- mem_wren  out  1  always 0
- mem_q  in  DATA_W  memory read data
- rd1_valid, rd2_valid  out  1  one-cycle read-return strobe
- rd1_data, rd2_data  out  DATA_W  returned data
- busy  out  1  at least one read is in flight

Function
REQ-004 At most one request SHALL be accepted per cycle.
REQ-005 reqN_ready SHALL be combinational and equal to the grant. Grant goes to the priority client if it is valid, otherwise to the other client if valid.
REQ-006 When both clients are valid, the non-priority client's ready SHALL be 0. Its request stays pending, and it must hold valid and addr until ready.
REQ-007 An acceptance at edge k SHALL load the granted address into mem_address at edge k. With no acceptance, mem_address SHALL hold its value.
REQ-008 Each acceptance SHALL push a tag {valid, client} into a shift pipeline of depth RD_LATENCY+1, advancing one stage per clock.
REQ-009 For an acceptance at edge k, mem_q SHALL be registered at edge k+RD_LATENCY+1 into the tagged client's rdN_data. rdN_valid SHALL be 1 for exactly that one cycle.
REQ-010 Total latency SHALL be RD_LATENCY+1 cycles (3 at default), with full throughput of one read per cycle.
REQ-011 Read returns SHALL preserve issue order. rd1_valid and rd2_valid SHALL never both be 1.
REQ-012 rdN_data SHALL hold its last value while rdN_valid is 0.
REQ-013 busy SHALL be the OR of all tag-stage valid bits.
REQ-014 When flush is 1, the block SHALL:
- clear all tag valids at the next edge;
- force both readies to 0 for that cycle (flush wins over a simultaneous request);
- produce no rdN_valid for discarded reads;
- leave mem_address unchanged.
REQ-015 A change of first_done SHALL take effect on the same cycle's grant. Reads already in flight SHALL complete to their original client.
REQ-016 mem_wren SHALL be constant 0. Write traffic is merged by the existing write-side mux.

Reset
REQ-017 Asserting rst_n low SHALL immediately clear:
- all tag valids, busy, and rd1_valid/rd2_valid;
- mem_address and rd1_data/rd2_data, to 0.
REQ-018 While rst_n is low, both readies SHALL be 0.
REQ-019 Reads in flight at reset SHALL be lost, with no return after release.
REQ-020 On the first edge after release, the block SHALL accept requests normally.

Structure
REQ-021 Package mem_rd_pkg SHALL hold the ADDR_W, DATA_W and RD_LATENCY defaults, enum client_e {CLIENT1, CLIENT2}, and struct rd_tag_t {valid, client}.
REQ-022 The tag shift pipeline SHALL be the sub-module rd_tag_pipe, parameterised by depth, with async reset and sync flush.
REQ-023 Arbitration and return-data registers SHALL live in mem_read_return. The memory model is bench-only.

Verification
REQ-024 The bench SHALL cover these directed scenarios (RD_LATENCY=2; memory model with 2-cycle latency, preloaded s[i]=i):
- Single read: first_done=0, client 1 reads addr 0x10 at edge 5 -> rd1_valid=1 after edge 8 only, rd1_data=0x10, rd2_valid=0 throughout.
- Contention: both clients valid, addr1=0x20, addr2=0x30, first_done=0 -> client 1 accepted first, client 2 on the next cycle; rd1_data=0x20 then rd2_data=0x30 on consecutive cycles.
- Priority flip: same stimulus with first_done=1 -> client 2 is served first. Toggling first_done while a read is in flight still returns the data to the issuing client.
- Streaming: client 2 reads addresses 0x00..0xFF back to back -> 256 consecutive rd2_valid pulses with data 0x00..0xFF in order, wrap-around handled at 0xFF, no gaps.
- Flush mid-stream: flush during the 3rd of 5 reads, together with a new request -> no ready that cycle, no returns for in-flight reads, busy=0 next cycle, later reads correct.
- Reset mid-operation: rst_n low asynchronously between edges with 2 reads in flight -> all outputs 0 immediately; after release, no stray rd_valid and a new read returns after 3 cycles.
